// File: rtl/sram_ctrl_pipe.sv
// Pipelined single-port SRAM controller: byte-lane writes, READ_LATENCY-deep read
// pipeline, illegal/out-of-range error strobe and a hardware zero sweep of the array.
module sram_ctrl_pipe #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_SIZE      = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY  = 2,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chip_enable_n,
  input  logic                    write_enable_n,
  input  logic                    read_enable_n,
  input  logic                    clear,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_enable,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    ready,
  output logic                    init_done,
  output logic                    error
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'b001,
    S_IDLE  = 3'b010,
    S_DRAIN = 3'b100
  } state_t;

  state_t                  r_state, w_next;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_SIZE];
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [READ_LATENCY-1:0] r_vld_p;
  logic [DATA_WIDTH-1:0]   r_dat_p [READ_LATENCY];
  logic                    w_req, w_wr, w_rd, w_illegal, w_oor, w_sweep_last, w_inflight;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  // A request presented together with clear is dropped along with the clear.
  assign ready        = (r_state == S_IDLE);
  assign w_req        = ready && !chip_enable_n && !clear;
  assign w_wr         = w_req && !write_enable_n && read_enable_n;
  assign w_rd         = w_req && write_enable_n && !read_enable_n;
  assign w_illegal    = w_req && !write_enable_n && !read_enable_n;
  assign w_oor        = 32'(address) >= MEM_SIZE;
  assign w_rd_word    = w_oor ? '0 : r_mem[address];
  assign w_sweep_last = (r_cnt == LAST);
  assign w_inflight   = |r_vld_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if (INIT_ON_RESET) r_state <= S_INIT;
      else               r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (w_sweep_last) w_next = S_IDLE;
      S_IDLE:  if (clear) w_next = w_inflight ? S_DRAIN : S_INIT;
      S_DRAIN: if (!w_inflight) w_next = S_INIT;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      init_done  <= !INIT_ON_RESET;
      r_vld_p    <= '0;
      data_valid <= 1'b0;
      error      <= 1'b0;
      data_out   <= '0;
    end else begin
      if (r_state == S_INIT) r_cnt <= w_sweep_last ? '0 : r_cnt + 1'b1;
      if (r_state == S_INIT && w_sweep_last) init_done <= 1'b1;
      else if (r_state == S_IDLE && clear)   init_done <= 1'b0;
      error <= w_illegal || ((w_wr || w_rd) && w_oor);
      // p0 captures the array at the accept edge; later stages only delay it
      r_vld_p[0] <= w_rd;
      for (int k = 1; k < READ_LATENCY; k++) r_vld_p[k] <= r_vld_p[k-1];
      // output stage: data_out keeps its last value between responses
      data_valid <= r_vld_p[READ_LATENCY-1];
      if (r_vld_p[READ_LATENCY-1]) data_out <= r_dat_p[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    r_dat_p[0] <= w_rd_word;
    for (int k = 1; k < READ_LATENCY; k++) r_dat_p[k] <= r_dat_p[k-1];
  end

  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr && !w_oor) begin
      for (int i = 0; i < NB; i++)
        if (byte_enable[i]) r_mem[address][8*i +: 8] <= data_in[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_sram_ctrl_pipe.sv
// Bench for sram_ctrl_pipe: two instances (256 words / latency 2 and 200 words / latency 3)
// share stimulus and are compared each cycle against a timestamp-based reference model.
module tb_sram_ctrl_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chip_enable_n = 1'b1, write_enable_n = 1'b1, read_enable_n = 1'b1, clear = 1'b0;
  logic [7:0]  address = 8'h0;
  logic [31:0] data_in = 32'h0;
  logic [3:0]  byte_enable = 4'h0;

  logic [31:0] dout_a, dout_b;
  logic        dv_a, dv_b, rdy_a, rdy_b, idn_a, idn_b, err_a, err_b;

  always #5 clk = ~clk;

  sram_ctrl_pipe #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(2),
                   .INIT_ON_RESET(1'b1)) u_a (
    .clk(clk), .reset(reset), .chip_enable_n(chip_enable_n), .write_enable_n(write_enable_n),
    .read_enable_n(read_enable_n), .clear(clear), .address(address), .data_in(data_in),
    .byte_enable(byte_enable), .data_out(dout_a), .data_valid(dv_a), .ready(rdy_a),
    .init_done(idn_a), .error(err_a));

  sram_ctrl_pipe #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_SIZE(200), .READ_LATENCY(3),
                   .INIT_ON_RESET(1'b1)) u_b (
    .clk(clk), .reset(reset), .chip_enable_n(chip_enable_n), .write_enable_n(write_enable_n),
    .read_enable_n(read_enable_n), .clear(clear), .address(address), .data_in(data_in),
    .byte_enable(byte_enable), .data_out(dout_b), .data_valid(dv_b), .ready(rdy_b),
    .init_done(idn_b), .error(err_b));

  logic [35:0] obs [2];
  assign obs[0] = {rdy_a, idn_a, err_a, dv_a, dout_a};
  assign obs[1] = {rdy_b, idn_b, err_b, dv_b, dout_b};

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  typedef struct {
    int          kind;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } op_t;

  int          cyc, checks, errors;
  int          rf [2];
  logic [31:0] mm [2][256];
  logic [31:0] last [2];
  logic [35:0] exp_v [2];
  rsp_t        q [2][$];

  function automatic int ms(input int j);
    return (j == 0) ? 256 : 200;
  endfunction

  function automatic int lat(input int j);
    return (j == 0) ? 2 : 3;
  endfunction

  // Model: ready once the edge count reaches rf[j]; reads answer at accept edge + latency.
  task automatic model_edge();
    bit          rdy, oor, e, v;
    logic [31:0] rv;
    for (int j = 0; j < 2; j++) begin
      rdy = (cyc - 1) >= rf[j];
      e = 1'b0;
      v = 1'b0;
      if (rdy && clear) begin
        rf[j] = (q[j].size() > 0) ? q[j][$].due + 1 + ms(j) : cyc + ms(j);
        for (int k = 0; k < 256; k++) mm[j][k] = 32'h0;
      end else if (rdy && !chip_enable_n) begin
        if (!write_enable_n && !read_enable_n) begin
          e = 1'b1;
        end else if (write_enable_n != read_enable_n) begin
          oor = int'(address) >= ms(j);
          e = oor;
          if (!write_enable_n) begin
            if (!oor)
              for (int i = 0; i < 4; i++)
                if (byte_enable[i]) mm[j][address][8*i +: 8] = data_in[8*i +: 8];
          end else begin
            rv = oor ? 32'h0 : mm[j][address];
            q[j].push_back('{due: cyc + lat(j), d: rv});
          end
        end
      end
      if (q[j].size() > 0 && q[j][0].due == cyc) begin
        v = 1'b1;
        last[j] = q[j][0].d;
        void'(q[j].pop_front());
      end
      exp_v[j] = {cyc >= rf[j], cyc >= rf[j], e, v, last[j]};
    end
  endtask

  task automatic step(input logic ce, input logic we, input logic re, input logic clr,
                      input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    chip_enable_n = ce; write_enable_n = we; read_enable_n = re; clear = clr;
    address = a; data_in = d; byte_enable = be;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
  endtask

  // kind: 0 idle, 1 write, 2 read, 3 illegal, 4 clear, 5 masked (both enables low, ce_n=1)
  task automatic op(input op_t o);
    case (o.kind)
      1:       step(1'b0, 1'b0, 1'b1, 1'b0, o.a, o.d, o.be);
      2:       step(1'b0, 1'b1, 1'b0, 1'b0, o.a, o.d, o.be);
      3:       step(1'b0, 1'b0, 1'b0, 1'b0, o.a, o.d, o.be);
      4:       step(1'b1, 1'b1, 1'b1, 1'b1, o.a, o.d, o.be);
      5:       step(1'b1, 1'b0, 1'b0, 1'b0, o.a, o.d, o.be);
      default: step(1'b1, 1'b1, 1'b1, 1'b0, o.a, o.d, o.be);
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    chip_enable_n = 1'b1; write_enable_n = 1'b1; read_enable_n = 1'b1; clear = 1'b0;
    for (int j = 0; j < 2; j++) begin
      q[j].delete();
      last[j] = 32'h0;
      rf[j] = ms(j);
      for (int k = 0; k < 256; k++) mm[j][k] = 32'h0;
      exp_v[j] = 36'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic test_reset();
    op_t o;
    do_reset();
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (obs[j] !== exp_v[j]) begin
        errors++;
        $display("FAIL reset_state inst%0d: got %h want %h", j, obs[j], exp_v[j]);
      end
    end
    for (int n = 0; n < 270; n++) begin
      o = '{0, 8'h0, 32'h0, 4'h0};
      if (n >= 258) o = '{2, 8'(n * 7), 32'h0, 4'h0};
      op(o);
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL init_sweep inst%0d cyc=%0d: got %h want %h", j, cyc, obs[j], exp_v[j]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t t[$];
    t = '{'{1, 8'h10, 32'hDEADBEEF, 4'hF}, '{1, 8'h10, 32'h000000AA, 4'h1},
          '{2, 8'h10, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0},
          '{0, 8'h0, 32'h0, 4'h0}, '{1, 8'h20, 32'h12345678, 4'hA}, '{2, 8'h20, 32'h0, 4'h0},
          '{0, 8'h0, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0}};
    for (int i = 0; i < t.size(); i++) begin
      op(t[i]);
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL back_to_back inst%0d step=%0d: got %h want %h", j, i, obs[j], exp_v[j]);
        end
      end
      if (i == 4) begin
        checks++;
        if (!(dv_a === 1'b1 && dout_a === 32'hDEADBEAA)) begin
          errors++;
          $display("FAIL lane_merge_lat2: valid=%b data=%h want valid=1 data=deadbeaa", dv_a, dout_a);
        end
      end
      if (i == 5) begin
        checks++;
        if (!(dv_b === 1'b1 && dout_b === 32'hDEADBEAA)) begin
          errors++;
          $display("FAIL lane_merge_lat3: valid=%b data=%h want valid=1 data=deadbeaa", dv_b, dout_b);
        end
      end
    end
  endtask

  task automatic test_pipelined();
    op_t t[$];
    logic [31:0] want;
    t = '{'{1, 8'h01, 32'h11111111, 4'hF}, '{1, 8'h02, 32'h22222222, 4'hF},
          '{1, 8'h03, 32'h33333333, 4'hF}, '{2, 8'h01, 32'h0, 4'h0}, '{2, 8'h02, 32'h0, 4'h0},
          '{2, 8'h03, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0},
          '{0, 8'h0, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0}};
    for (int i = 0; i < t.size(); i++) begin
      op(t[i]);
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL pipelined inst%0d step=%0d: got %h want %h", j, i, obs[j], exp_v[j]);
        end
      end
      if (i >= 6 && i <= 8) begin
        want = {4{8'(8'h11 * (i - 5))}};
        checks++;
        if (!(dv_b === 1'b1 && dout_b === want)) begin
          errors++;
          $display("FAIL order_lat3 step=%0d: valid=%b data=%h want valid=1 data=%h", i, dv_b, dout_b, want);
        end
      end
    end
  endtask

  task automatic test_errors();
    op_t t[$];
    t = '{'{3, 8'h10, 32'hFFFFFFFF, 4'hF}, '{5, 8'h10, 32'hFFFFFFFF, 4'hF},
          '{1, 8'hF0, 32'hCAFEF00D, 4'hF}, '{2, 8'hF0, 32'h0, 4'h0}, '{2, 8'h10, 32'h0, 4'h0},
          '{0, 8'h0, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0}};
    for (int i = 0; i < t.size(); i++) begin
      op(t[i]);
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL errors inst%0d step=%0d: got %h want %h", j, i, obs[j], exp_v[j]);
        end
      end
      if (i == 0) begin
        checks++;
        if (!(err_a === 1'b1 && dv_a === 1'b0)) begin
          errors++;
          $display("FAIL illegal_pulse: error=%b valid=%b want error=1 valid=0", err_a, dv_a);
        end
      end
      if (i == 1) begin
        checks++;
        if (err_a !== 1'b0) begin
          errors++;
          $display("FAIL masked_no_error: error=%b want 0", err_a);
        end
      end
      if (i == 6) begin
        checks++;
        if (!(dv_b === 1'b1 && dout_b === 32'h0)) begin
          errors++;
          $display("FAIL oor_read_zero: valid=%b data=%h want valid=1 data=0", dv_b, dout_b);
        end
      end
    end
  endtask

  task automatic test_random();
    op_t o;
    int  r;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      o.a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
      o.d = $urandom;
      o.be = 4'($urandom_range(0, 15));
      if (r < 35)      o.kind = 1;
      else if (r < 75) o.kind = 2;
      else if (r < 80) o.kind = 3;
      else if (r < 85) o.kind = 5;
      else if (r < 86) o.kind = 4;
      else             o.kind = 0;
      op(o);
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL random inst%0d cyc=%0d: got %h want %h", j, cyc, obs[j], exp_v[j]);
        end
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int n = 0; n < 700 && !(cyc >= rf[0] && cyc >= rf[1]); n++) begin
      op('{0, 8'h0, 32'h0, 4'h0});
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL %s inst%0d cyc=%0d: got %h want %h", tag, j, cyc, obs[j], exp_v[j]);
        end
      end
    end
  endtask

  task automatic test_clear();
    op_t t[$];
    wait_ready("pre_clear");
    t = '{'{1, 8'h05, 32'hA5A5A5A5, 4'hF}, '{1, 8'h06, 32'h5A5A5A5A, 4'hF},
          '{2, 8'h05, 32'h0, 4'h0}, '{2, 8'h06, 32'h0, 4'h0}, '{4, 8'h05, 32'h0, 4'h0}};
    for (int i = 0; i < t.size(); i++) begin
      op(t[i]);
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL clear_setup inst%0d step=%0d: got %h want %h", j, i, obs[j], exp_v[j]);
        end
      end
    end
    checks++;
    if (!(rdy_a === 1'b0 && idn_a === 1'b0 && rdy_b === 1'b0 && idn_b === 1'b0)) begin
      errors++;
      $display("FAIL clear_drops_ready: ready=%b%b init_done=%b%b want 00/00", rdy_a, rdy_b, idn_a, idn_b);
    end
    wait_ready("clear_sweep");
    t = '{'{2, 8'h05, 32'h0, 4'h0}, '{2, 8'h06, 32'h0, 4'h0}, '{2, 8'h10, 32'h0, 4'h0},
          '{0, 8'h0, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0}, '{0, 8'h0, 32'h0, 4'h0}};
    for (int i = 0; i < t.size(); i++) begin
      op(t[i]);
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL clear_zero inst%0d step=%0d: got %h want %h", j, i, obs[j], exp_v[j]);
        end
      end
    end
    checks++;
    if (dout_a !== 32'h0) begin
      errors++;
      $display("FAIL clear_zero_data: data=%h want 0", dout_a);
    end
  endtask

  task automatic test_mid_reset();
    op('{1, 8'h30, 32'h87654321, 4'hF});
    op('{2, 8'h30, 32'h0, 4'h0});
    do_reset();
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (obs[j] !== exp_v[j]) begin
        errors++;
        $display("FAIL mid_reset_state inst%0d: got %h want %h", j, obs[j], exp_v[j]);
      end
    end
    for (int n = 0; n < 120; n++) begin
      op('{0, 8'h0, 32'h0, 4'h0});
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL mid_reset_flush inst%0d cyc=%0d: got %h want %h", j, cyc, obs[j], exp_v[j]);
        end
      end
    end
    do_reset();
    wait_ready("resweep");
    for (int n = 0; n < 6; n++) begin
      op('{(n < 2) ? 2 : 0, 8'h30, 32'h0, 4'h0});
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== exp_v[j]) begin
          errors++;
          $display("FAIL resweep_read inst%0d cyc=%0d: got %h want %h", j, cyc, obs[j], exp_v[j]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_back_to_back();
    test_pipelined();
    test_errors();
    test_random();
    test_clear();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
